dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the pipeline CPU's MEM-stage data accesses. It accepts one load or store request at a time over a valid/ready handshake and holds a word-addressed data store. It inserts a programmable number of wait states and returns a one-cycle response. `busy` feeds the CPU's stall logic, so the pipeline freezes while an access is outstanding.

## Interface
Parameters:
- `ADDR_W`, default 6: word-address width; the store holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 2: wait states between accept and response; legal range 0–15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset; internal state clears immediately while low.
- `req_valid` input 1: request present.
- `req_write` input 1: 1 = store, 0 = load.
- `req_addr` input ADDR_W+2: byte address; bits [1:0] must be 00.
- `req_wdata` input 32: store data.
- `req_ready` output 1: responder can accept a request this cycle.
- `resp_valid` output 1: response strobe, high for exactly one cycle.
- `resp_rdata` output 32: load data; 0 for stores and errors.
- `resp_err` output 1: qualifies `resp_valid`; set for a misaligned address.
- `busy` output 1: an access is outstanding; drives the CPU stall.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - `req_ready`=1 and `busy`=0.
  - On `req_valid`&`req_ready`, latch write, addr and wdata, then compute misalign = `req_addr[1:0]`!=0.
  - If misaligned, go to RESP with the error flag set.
  - Else if `WAIT_CYCLES`=0, go to RESP.
  - Else load wait counter = `WAIT_CYCLES`-1 and go to WAIT.
- **WAIT**
  - `req_ready`=0 and `busy`=1.
  - Counter decrements each cycle; at 0, go to RESP.
  - `req_valid` is ignored in this state.
- **RESP**
  - `resp_valid`=1 and `busy`=1.
  - Store: write wdata into word `addr[ADDR_W+1:2]` on this edge; `resp_rdata`=0.
  - Load: `resp_rdata` = current content of that word.
  - Error: no array access; `resp_rdata`=0 and `resp_err`=1.
  - Next state is always IDLE.
- Stores never alter any other word.
- The storage array is not reset; its contents survive reset.

## Timing
- Reset values (async, while `reset`=0): state IDLE, counter 0, latched request 0, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `busy`=0.
- If reset is asserted in WAIT or RESP, the access is aborted and no write is committed.
- Latency:
  - Request accepted at edge t: `resp_valid` is high during cycle t+1+`WAIT_CYCLES`.
  - Misaligned request: response always at t+1, regardless of `WAIT_CYCLES`.
- Throughput:
  - Next accept is no earlier than the edge after the RESP cycle.
  - Minimum spacing between accepts is `WAIT_CYCLES`+2 cycles; with `WAIT_CYCLES`=0 it is 2.
- All outputs are registered, except `req_ready` and `busy`, which decode from the state register (no input-to-output combinational path).
- A request held valid through WAIT and RESP is not re-accepted until the responder is back in IDLE. The requester deasserts after the accept edge.

## Structure
- Shared package `dmem_pkg` holds:
  - state enum `dmem_state_t` {IDLE, WAIT, RESP};
  - `DMEM_DATA_W`=32;
  - `DMEM_WAIT_W`=4, the counter width.
- Sub-module `dmem_array`:
  - 2^ADDR_W×32 array, single port;
  - synchronous write with `we`, combinational read.
  - It is instantiated once.
- FSM, counter and request latch stay in the top module.

## Test plan
- **Reset:** assert `reset`=0 mid-WAIT of a store of 0xDEADBEEF to 0x10, release, then load 0x10. Required: `req_ready`=1, `busy`=0 and `resp_valid`=0 during reset; the load does not return 0xDEADBEEF (the word keeps its pre-store value).
- **Store then load, `WAIT_CYCLES`=2:** store 0x12345678 to 0x08, accepted at t. Required: `resp_valid` at t+3 with `resp_rdata`=0, `busy` high t+1..t+3. Then a load from 0x08 returns 0x12345678 exactly 3 cycles after its accept.
- **Zero wait (`WAIT_CYCLES`=0):** back-to-back loads held valid. Required: accepts occur every 2 cycles, each `resp_valid` one cycle after its accept, and `req_ready` alternates 1/0.
- **Misaligned address:** load from 0x0A. Required: `resp_valid`=1 and `resp_err`=1 at t+1, `resp_rdata`=0, and a following load of 0x08 still returns its earlier value.
- **Address wrap and isolation:** store 0xAAAAAAAA to 0xFC (word 63) and 0x55555555 to 0x00 (word 0). Required: the two loads return the respective values, and `req_valid` pulses during WAIT are never accepted.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and widths for the MEM-stage data responder.
package dmem_pkg;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// Single-port word store: synchronous write, combinational read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DMEM_DATA_W-1:0] wdata,
    output logic [DMEM_DATA_W-1:0] rdata
);
    logic [DMEM_DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one access at a time, programmable wait states,
// single-cycle registered response; busy stalls the CPU pipeline.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [ADDR_W+1:0]      req_addr,
    input  logic [DMEM_DATA_W-1:0] req_wdata,
    output logic                   req_ready,
    output logic                   resp_valid,
    output logic [DMEM_DATA_W-1:0] resp_rdata,
    output logic                   resp_err,
    output logic                   busy
);
    localparam logic [DMEM_WAIT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : DMEM_WAIT_W'(WAIT_CYCLES - 1);

    dmem_state_t              state, stateNext;
    logic [DMEM_WAIT_W-1:0]   waitCnt, waitCntNext;
    logic                     latWrite, latErr;
    logic [ADDR_W-1:0]        latWord;
    logic [DMEM_DATA_W-1:0]   latWdata;
    logic                     misalign, accept;
    logic                     writeSel, errSel;
    logic [ADDR_W-1:0]        arrAddr;
    logic [DMEM_DATA_W-1:0]   arrRdata;
    logic                     arrWe;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign misalign  = (req_addr[1:0] != 2'b00);
    assign accept    = req_ready && req_valid;

    // On the accept edge the request is not latched yet, so look at the inputs.
    assign writeSel = (state == IDLE) ? req_write : latWrite;
    assign errSel   = (state == IDLE) ? misalign  : latErr;
    assign arrAddr  = (state == IDLE) ? req_addr[ADDR_W+1:2] : latWord;
    assign arrWe    = (state == RESP) && latWrite && !latErr;

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misalign || (WAIT_CYCLES == 0)) begin
                        stateNext = RESP;
                    end else begin
                        stateNext   = WAIT;
                        waitCntNext = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (waitCnt == '0) begin
                    stateNext = RESP;
                end else begin
                    waitCntNext = waitCnt - 1'b1;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            waitCnt    <= '0;
            latWrite   <= 1'b0;
            latErr     <= 1'b0;
            latWord    <= '0;
            latWdata   <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (accept) begin
                latWrite <= req_write;
                latErr   <= misalign;
                latWord  <= req_addr[ADDR_W+1:2];
                latWdata <= req_wdata;
            end
            // No write can land between this read and the RESP cycle, so the
            // sampled word equals the array content during RESP.
            resp_valid <= (stateNext == RESP);
            resp_err   <= (stateNext == RESP) && errSel;
            resp_rdata <= ((stateNext == RESP) && !errSel && !writeSel) ? arrRdata : '0;
        end
    end

    dmem_array #(
        .ADDR_W(ADDR_W)
    ) uArray (
        .clk  (clk),
        .we   (arrWe),
        .addr (arrAddr),
        .wdata(latWdata),
        .rdata(arrRdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: a 2-wait-state and a zero-wait responder against a word model.
module tb_dmem_responder;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reqWrite = 1'b0;
    logic [7:0]  reqAddr = '0;
    logic [31:0] reqWdata = '0;
    logic        valid2 = 1'b0, valid0 = 1'b0;
    logic        rdy2, rdy0, respValid2, respValid0, respErr2, respErr0, busy2, busy0;
    logic [31:0] respRdata2, respRdata0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t q2[$];
    exp_t q0[$];
    logic [31:0] model2 [64];
    logic [31:0] model0 [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(valid2), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(rdy2),
        .resp_valid(respValid2), .resp_rdata(respRdata2), .resp_err(respErr2), .busy(busy2)
    );

    dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(valid0), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(rdy0),
        .resp_valid(respValid0), .resp_rdata(respRdata0), .resp_err(respErr0), .busy(busy0)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    // Expected response is pushed at the negedge preceding the accept edge.
    task automatic pushExp(input int d, input bit wr, input logic [7:0] addr, input logic [31:0] data);
        exp_t e;
        bit   err = (addr[1:0] != 2'b00);
        int   wc  = err ? 0 : ((d == 2) ? 2 : 0);
        int   w   = int'(addr[7:2]);
        e.err   = err;
        e.cyc   = cyc + 1 + wc;
        e.rdata = 32'h0;
        if (!err && !wr) e.rdata = (d == 2) ? model2[w] : model0[w];
        if (!err && wr) begin
            if (d == 2) model2[w] = data;
            else        model0[w] = data;
        end
        if (d == 2) q2.push_back(e);
        else        q0.push_back(e);
    endtask

    task automatic issue(input int d, input bit wr, input logic [7:0] addr,
                         input logic [31:0] data, input bit push);
        int n = 0;
        @(negedge clk);
        while (((d == 2) ? rdy2 : rdy0) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkEq("readyTimeout", 32'd0, 32'd1);
        reqWrite = wr;
        reqAddr  = addr;
        reqWdata = data;
        if (d == 2) valid2 = 1'b1;
        else        valid0 = 1'b1;
        if (push) pushExp(d, wr, addr, data);
        @(posedge clk);
        #1;
        valid2 = 1'b0;
        valid0 = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((q2.size() != 0 || q0.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkEq("drainTimeout", 32'(q2.size() + q0.size()), 32'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (respValid2 === 1'b1) begin
            if (q2.size() == 0) checkEq("unexpResp2", 32'd1, 32'd0);
            else begin
                e = q2.pop_front();
                checkEq("rdata2", respRdata2, e.rdata);
                checkEq("err2", 32'(respErr2), 32'(e.err));
                checkEq("latency2", 32'(cyc), 32'(e.cyc));
            end
        end
        if (respValid0 === 1'b1) begin
            if (q0.size() == 0) checkEq("unexpResp0", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                checkEq("rdata0", respRdata0, e.rdata);
                checkEq("err0", 32'(respErr0), 32'(e.err));
                checkEq("latency0", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #12;
        checkEq("rstReady", 32'(rdy2), 32'd1);
        checkEq("rstBusy", 32'(busy2), 32'd0);
        checkEq("rstRespValid", 32'(respValid2), 32'd0);
        checkEq("rstRespErr", 32'(respErr2), 32'd0);
        checkEq("rstRdata", respRdata2, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Store then load with two wait states, checking busy/ready window.
        issue(2, 1'b1, 8'h08, 32'h12345678, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkEq("busyWin", 32'(busy2), 32'd1);
            checkEq("readyWin", 32'(rdy2), 32'd0);
        end
        @(negedge clk);
        checkEq("busyIdle", 32'(busy2), 32'd0);
        checkEq("readyIdle", 32'(rdy2), 32'd1);
        issue(2, 1'b0, 8'h08, 32'h0, 1'b1);
        waitDrain();

        // Misaligned load errors at t+1 and leaves the stored word intact.
        issue(2, 1'b0, 8'h0A, 32'h0, 1'b1);
        issue(2, 1'b0, 8'h08, 32'h0, 1'b1);
        waitDrain();

        // Reset mid-WAIT aborts the store.
        issue(2, 1'b1, 8'h10, 32'h11111111, 1'b1);
        waitDrain();
        issue(2, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkEq("abortReady", 32'(rdy2), 32'd1);
        checkEq("abortBusy", 32'(busy2), 32'd0);
        checkEq("abortRespValid", 32'(respValid2), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        issue(2, 1'b0, 8'h10, 32'h0, 1'b1);
        waitDrain();

        // Address extremes; valid pulses during WAIT must be ignored.
        issue(2, 1'b1, 8'hFC, 32'hAAAAAAAA, 1'b1);
        @(negedge clk);
        reqWrite = 1'b1; reqAddr = 8'h00; reqWdata = 32'hBAD0BAD0; valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        issue(2, 1'b1, 8'h00, 32'h55555555, 1'b1);
        @(negedge clk);
        reqWrite = 1'b1; reqAddr = 8'hFC; reqWdata = 32'hBAD1BAD1; valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        issue(2, 1'b0, 8'hFC, 32'h0, 1'b1);
        issue(2, 1'b0, 8'h00, 32'h0, 1'b1);
        waitDrain();

        // Zero wait: loads held valid are accepted every other cycle.
        issue(0, 1'b1, 8'h08, 32'hCAFEF00D, 1'b1);
        reqWrite = 1'b0;
        reqAddr  = 8'h08;
        valid0   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkEq("readyAlt", 32'(rdy0), (i % 2 == 0) ? 32'd0 : 32'd1);
            if (rdy0 === 1'b1) pushExp(0, 1'b0, 8'h08, 32'h0);
        end
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        waitDrain();

        checkEq("q2Empty", 32'(q2.size()), 32'd0);
        checkEq("q0Empty", 32'(q0.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
